// File: rtl/outport_scan_display.sv
// Multiplexed hex display for the 32-bit output port: one shared active-low
// 7-seg+DP bus, one-hot-low digit enables, frame-aligned update of the shown value.
module outport_scan_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           in_data,
    input  logic                  in_load,
    input  logic [NUM_DIGITS-1:0] in_dp,
    input  logic                  in_blank_zeros,
    output logic [7:0]            out_seg,
    output logic [NUM_DIGITS-1:0] out_digit_n,
    output logic                  out_frame
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [DW-1:0]         r_disp;
    logic [DW-1:0]         r_pend;
    logic                  r_pend_v;

    logic                  w_tc;
    logic                  w_wrap;
    logic [3:0]            w_nib;
    logic                  w_dp;
    logic                  w_blank;
    logic [NUM_DIGITS-1:0] w_lz;
    logic [7:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_dig_n;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    assign w_tc   = (r_presc == PW'(REFRESH_DIV - 1));
    // Any out-of-range index is treated as the last digit so it recovers to 0.
    assign w_wrap = w_tc && (r_idx >= IW'(NUM_DIGITS - 1));

    always_comb begin
        w_nib   = 4'h0;
        w_dp    = 1'b0;
        w_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_lz[i] = ~|(r_disp >> (4 * i));
            if (r_idx == IW'(i)) begin
                w_nib   = r_disp[4*i +: 4];
                w_dp    = in_dp[i];
                w_blank = in_blank_zeros && (i > 0) && w_lz[i];
            end
        end
        w_seg   = w_blank ? 8'hFF : {~w_dp, hex7(w_nib)};
        w_dig_n = ~(NUM_DIGITS'(1) << r_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_disp      <= '0;
            r_pend      <= '0;
            r_pend_v    <= 1'b0;
            out_seg     <= 8'hFF;
            out_digit_n <= '1;
            out_frame   <= 1'b0;
        end else begin
            r_presc <= w_tc ? '0 : r_presc + PW'(1);
            if (w_tc)
                r_idx <= w_wrap ? '0 : r_idx + IW'(1);

            // A load landing on the boundary edge bypasses the pending register.
            if (w_wrap) begin
                if (in_load)
                    r_disp <= in_data[DW-1:0];
                else if (r_pend_v)
                    r_disp <= r_pend;
                r_pend_v <= 1'b0;
            end else if (in_load) begin
                r_pend   <= in_data[DW-1:0];
                r_pend_v <= 1'b1;
            end

            out_seg     <= w_seg;
            out_digit_n <= w_dig_n;
            out_frame   <= (r_idx == '0) && (r_presc == '0);
        end
    end

endmodule

// File: doc/outport_scan_display.md
Name: outport_scan_display

Overview:
- Downstream consumer of the processor's 32-bit output port register.
- Time-multiplexes NUM_DIGITS hex digits onto one shared active-low 7-segment+DP bus with active-low digit enables. Replaces the per-nibble static decoders on boards with a common-segment display.
- Captures new outport values on a write strobe and applies them only at frame boundaries, so the display never tears mid-scan.
- Optionally blanks leading zeros.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit is driven (≥2).
- NUM_DIGITS, 8, number of scanned digits (1..8). Digit i shows in_data[4i+3:4i].

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_data  input  32  outport value (same value the datapath's out_outport drives)
- in_load  input  1  one-cycle strobe; capture in_data (tie to outport write)
- in_dp  input  NUM_DIGITS  decimal-point request per digit, active-high
- in_blank_zeros  input  1  1 = blank leading zero digits
- out_seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered
- out_digit_n  output  NUM_DIGITS  digit enables, active-low, one-hot-low, registered
- out_frame  output  1  one-cycle pulse at start of each frame, registered

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - prescaler=0, digit index=0, display reg=0, pending reg=0, pending_valid=0.
  - out_seg=8'hFF, out_digit_n=all 1s, out_frame=0.
  - Reset mid-scan or mid-load discards pending data.
- Prescaler: counts 0..REFRESH_DIV-1, wraps to 0. At terminal count, digit index increments, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary: the cycle where index wraps to 0. On that edge:
  - If pending_valid, display reg <= pending and pending_valid <= 0.
  - out_frame is 1 on the following cycle (aligned with digit 0's first output cycle).
- Load:
  - in_load=1 sets pending <= in_data, pending_valid <= 1.
  - Multiple loads within a frame: last wins.
  - Load on the same edge as a frame boundary: display reg <= in_data directly (bypass), pending_valid <= 0.
- Output latency: outputs are registered from current index/display reg, one cycle behind the index. Each digit is driven for exactly REFRESH_DIV cycles.
  - First cycle after reset release: outputs still all-off.
  - Digit 0 is driven from the second cycle.
- out_digit_n: bit index = 0, all others = 1. Never more than one low.
- Hex decode, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - out_seg[7] = ~in_dp[index]. in_dp is sampled live, not latched.
- Leading-zero blanking:
  - Digit i (i>0) is blanked when in_blank_zeros=1 and nibbles i..NUM_DIGITS-1 of the display reg are all zero.
  - Blanked digit: out_seg=8'hFF, including DP. Its enable is still asserted, to keep the duty cycle constant.
  - Digit 0 is never blanked.
- in_data[31:4*NUM_DIGITS] is ignored.
- Unused states: index ≥ NUM_DIGITS is unreachable. If ever reached, next advance goes to 0.

Test Plan:
(Bench uses REFRESH_DIV=4, NUM_DIGITS=8.)
- Reset then release, no load -> 1 cycle all-off. Then digit 0 low in out_digit_n=8'hFE with out_seg=8'hC0 for 4 cycles. Digits 1..7 show 8'hC0 (blank_zeros=0). Frame period = 32 cycles, out_frame pulses every 32.
- Load 32'h0000_00A5 mid-frame, blank_zeros=1 -> current frame unchanged. Next frame: digit0=8'h92, digit1=8'h88, digits 2..7=8'hFF with enables still cycling.
- Load 32'h1111_1111 then 32'h89AB_CDEF in the same frame -> next frame shows only the second value: digit0=8'h8E ... digit7=8'h80.
- Load asserted on the exact frame-boundary edge with 32'h0000_0007 -> digit 0 of the immediately starting frame shows 8'hF8.
- in_dp=8'h04, value 32'h0000_0003 -> digit 2 blank when blank_zeros=1 (8'hFF), shows 8'h40 when blank_zeros=0. digit0=8'hB0.
- Assert reset mid-frame with pending load -> next cycle outputs 8'hFF / all 1s. After release, display shows 0, not the pending value.
